// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin owner of one shared SPI byte engine; runs multi-byte
// bursts per requester. Define SPI_ARB_TIMEOUT_EN to add the per-byte watchdog.
module spi_xfer_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LENW    = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] req_len,
    input  logic [NREQ*2-1:0]    req_mode,
    input  logic [NREQ*8-1:0]    tx_data,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      tx_ack,
    output logic                 rx_valid,
    output logic [7:0]           rx_data,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_err,
    output logic                 eng_en,
    output logic                 eng_we,
    output logic                 eng_oe,
    output logic                 eng_cpol,
    output logic                 eng_cpha,
    output logic [7:0]           eng_wdata,
    input  logic [7:0]           eng_rdata,
    input  logic                 eng_busy,
    input  logic                 eng_done
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE, ARB, LOAD, RUN, DRAIN, CAPT, FIN
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   own_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] tx_ack_q;
    logic [NREQ-1:0] req_done_q;
    logic [LENW-1:0] cnt_q;
    logic            en_q;
    logic            we_q;
    logic            oe_q;
    logic            rx_valid_q;
    logic            cpol_q;
    logic            cpha_q;
    logic [7:0]      wdata_q;
    logic [7:0]      rx_data_q;

    logic [LENW-1:0] len_a  [NREQ];
    logic [1:0]      mode_a [NREQ];
    logic [7:0]      txd_a  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign len_a[g]  = req_len[g*LENW +: LENW];
        assign mode_a[g] = req_mode[g*2 +: 2];
        assign txd_a[g]  = tx_data[g*8 +: 8];
    end

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_param_check
        $error("spi_xfer_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
    end

    // Search starts at ptr_q, so the previous owner is considered last.
    logic            win_vld;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic [NREQ-1:0] win_oh;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(ptr_q) + i) % NREQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign win_oh = NREQ'(1) << win_idx;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   to_cnt_q;
    logic [NREQ-1:0] req_err_q;
    logic            to_hit;
    assign to_hit  = (to_cnt_q == TW'(TIMEOUT - 1));
    assign req_err = req_err_q;
`else
    assign req_err = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            own_q      <= '0;
            grant_q    <= '0;
            tx_ack_q   <= '0;
            req_done_q <= '0;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            oe_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            wdata_q    <= '0;
            rx_data_q  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt_q   <= '0;
            req_err_q  <= '0;
`endif
        end else begin
            tx_ack_q   <= '0;
            req_done_q <= '0;
            we_q       <= 1'b0;
            oe_q       <= 1'b0;
            rx_valid_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            req_err_q  <= '0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (|req) state_q <= ARB;
                end
                ARB: begin
                    if (win_vld) begin
                        own_q            <= win_idx;
                        grant_q          <= win_oh;
                        cnt_q            <= (len_a[win_idx] == '0) ? '0
                                            : len_a[win_idx] - LENW'(1);
                        {cpol_q, cpha_q} <= mode_a[win_idx];
                        we_q             <= 1'b1;
                        wdata_q          <= txd_a[win_idx];
                        tx_ack_q         <= win_oh;
                        state_q          <= LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    wdata_q <= '0;
                    en_q    <= 1'b1;
                    state_q <= RUN;
`ifdef SPI_ARB_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                end
                RUN: begin
                    if (eng_done) begin
                        en_q    <= 1'b0;
                        state_q <= DRAIN;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        en_q      <= 1'b0;
                        req_err_q <= grant_q;
                        state_q   <= FIN;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
`endif
                end
                DRAIN: begin
                    if (!eng_busy) begin
                        oe_q    <= 1'b1;
                        state_q <= CAPT;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        req_err_q <= grant_q;
                        state_q   <= FIN;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
`endif
                end
                CAPT: begin
                    rx_data_q  <= eng_rdata;
                    rx_valid_q <= 1'b1;
                    if (cnt_q == '0) begin
                        req_done_q <= grant_q;
                        state_q    <= FIN;
                    end else begin
                        cnt_q    <= cnt_q - LENW'(1);
                        we_q     <= 1'b1;
                        wdata_q  <= txd_a[own_q];
                        tx_ack_q <= grant_q;
                        state_q  <= LOAD;
                    end
                end
                FIN: begin
                    grant_q <= '0;
                    ptr_q   <= (own_q == IW'(NREQ - 1)) ? '0 : own_q + IW'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // In DRAIN the enable follows busy so the engine finishes its byte and then parks.
    assign eng_en    = en_q | ((state_q == DRAIN) & eng_busy);
    assign eng_we    = we_q;
    assign eng_oe    = oe_q;
    assign eng_cpol  = cpol_q;
    assign eng_cpha  = cpha_q;
    assign eng_wdata = wdata_q;
    assign grant     = grant_q;
    assign tx_ack    = tx_ack_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign req_done  = req_done_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter; a small behavioural byte engine answers every
// written byte with that byte XOR 0x99.
module tb_spi_xfer_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned LENW = 4;
    localparam logic [7:0]  KEY  = 8'h99;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*LENW-1:0] req_len;
    logic [NREQ*2-1:0]    req_mode;
    logic [NREQ*8-1:0]    tx_data;
    logic [NREQ-1:0]      grant, tx_ack, req_done, req_err;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 eng_en, eng_we, eng_oe, eng_cpol, eng_cpha;
    logic [7:0]           eng_wdata, eng_rdata;
    logic                 eng_busy, eng_done;

    always #5 clk = ~clk;

    spi_xfer_arbiter #(.NREQ(NREQ), .LENW(LENW), .TIMEOUT(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .req_mode  (req_mode),
        .tx_data   (tx_data),
        .grant     (grant),
        .tx_ack    (tx_ack),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .req_done  (req_done),
        .req_err   (req_err),
        .eng_en    (eng_en),
        .eng_we    (eng_we),
        .eng_oe    (eng_oe),
        .eng_cpol  (eng_cpol),
        .eng_cpha  (eng_cpha),
        .eng_wdata (eng_wdata),
        .eng_rdata (eng_rdata),
        .eng_busy  (eng_busy),
        .eng_done  (eng_done)
    );

    logic [37:0] outs;
    assign outs = {grant, tx_ack, rx_valid, rx_data, req_done, req_err,
                   eng_en, eng_we, eng_oe, eng_cpol, eng_cpha, eng_wdata};

    // Engine: starts on en, done pulse after a few cycles, busy one cycle past done.
    logic [1:0] e_st, e_cnt;
    logic [7:0] e_wbyte;
    always @(posedge clk) begin
        if (rst) begin
            e_st <= 2'd0; e_cnt <= 2'd0; e_wbyte <= 8'h00;
            eng_busy <= 1'b0; eng_done <= 1'b0; eng_rdata <= 8'h00;
        end else begin
            if (eng_we) e_wbyte <= eng_wdata;
            case (e_st)
                2'd0: if (eng_en) begin eng_busy <= 1'b1; e_cnt <= 2'd2; e_st <= 2'd1; end
                2'd1: if (e_cnt == 2'd0) begin
                          eng_done <= 1'b1; eng_rdata <= e_wbyte ^ KEY; e_st <= 2'd2;
                      end else e_cnt <= e_cnt - 2'd1;
                2'd2: begin eng_done <= 1'b0; e_st <= 2'd3; end
                default: begin eng_busy <= 1'b0; e_st <= 2'd0; end
            endcase
        end
    end

    int         ack_cnt  [NREQ] = '{default: 0};
    int         done_cnt [NREQ] = '{default: 0};
    int         err_cnt  [NREQ] = '{default: 0};
    int         ack_base [NREQ] = '{default: 0};
    int         done_base[NREQ] = '{default: 0};
    int         both_cnt = 0;
    int         mode_bad = 0;
    logic [7:0] rx_q[$];
    int         grant_log[$];
    logic [1:0] mode_log[$];
    logic [7:0] txbuf [NREQ][16];
    int         rx_base = 0, g_base = 0, mb_base = 0;

    // Monitor, sampling 1 time unit after each rising edge; also feeds tx_data.
    initial begin
        logic [NREQ-1:0] last_grant;
        int d, gi;
        last_grant = '0;
        tx_data    = '0;
        forever begin
            @(posedge clk); #1;
            for (int r = 0; r < NREQ; r++) begin
                if (tx_ack[r])   ack_cnt[r]++;
                if (req_done[r]) done_cnt[r]++;
                if (req_err[r])  err_cnt[r]++;
                d = ack_cnt[r] - ack_base[r];
                if (d < 0)  d = 0;
                if (d > 15) d = 15;
                tx_data[r*8 +: 8] = txbuf[r][d];
            end
            if (rx_valid) rx_q.push_back(rx_data);
            if (eng_we && eng_en) both_cnt++;
            if (grant != '0 && grant != last_grant) begin
                gi = 0;
                for (int r = 0; r < NREQ; r++) if (grant[r]) gi = r;
                grant_log.push_back(gi);
                mode_log.push_back({eng_cpol, eng_cpha});
            end else if (grant != '0 && {eng_cpol, eng_cpha} != mode_log[$]) begin
                mode_bad++;
            end
            last_grant = grant;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        for (int r = 0; r < NREQ; r++) begin
            ack_base[r]  = ack_cnt[r];
            done_base[r] = done_cnt[r];
        end
        rx_base = rx_q.size();
        g_base  = grant_log.size();
        mb_base = mode_bad;
    endtask

    task automatic wait_done(input int r, input int budget, input string tag);
        int n = 0;
        while (!req_done[r] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(req_done[r]), 64'(1));
        req[r] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        int rr_exp [5] = '{0, 1, 2, 3, 0};
        rst = 1'b1; req = '0; req_len = '0; req_mode = '0;
        for (int r = 0; r < NREQ; r++)
            for (int k = 0; k < 16; k++) txbuf[r][k] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", 64'(outs), 64'(0));

        // Requester 1, one byte, mode 00.
        txbuf[1][0] = 8'hA5; req_len[7:4] = 4'd1; req_mode[3:2] = 2'b00;
        snap();
        @(negedge clk); req[1] = 1'b1;
        @(negedge clk); check("t1_arb_no_grant", 64'(grant), 64'(0));
        @(negedge clk);
        check("t1_grant",    64'(grant), 64'(4'b0010));
        check("t1_load_ctl", 64'({eng_we, eng_en}), 64'(2'b10));
        check("t1_wdata",    64'(eng_wdata), 64'(8'hA5));
        check("t1_tx_ack",   64'(tx_ack), 64'(4'b0010));
        wait_done(1, 100, "t1");
        check("t1_acks",  64'(ack_cnt[1] - ack_base[1]), 64'(1));
        check("t1_rx_n",  64'(rx_q.size() - rx_base), 64'(1));
        check("t1_rx0",   64'(rx_q[rx_base]), 64'(8'h3C));
        check("t1_dones", 64'(done_cnt[1] - done_base[1]), 64'(1));
        check("t1_mode",  64'(mode_log[$]), 64'(2'b00));

        // Requester 2, three bytes, mode 11.
        txbuf[2][0] = 8'h11; txbuf[2][1] = 8'h22; txbuf[2][2] = 8'h33;
        req_len[11:8] = 4'd3; req_mode[5:4] = 2'b11;
        snap();
        @(negedge clk); req[2] = 1'b1;
        wait_done(2, 200, "t2");
        check("t2_acks",     64'(ack_cnt[2] - ack_base[2]), 64'(3));
        check("t2_rx_n",     64'(rx_q.size() - rx_base), 64'(3));
        check("t2_rx0",      64'(rx_q[rx_base]),     64'(8'h88));
        check("t2_rx1",      64'(rx_q[rx_base + 1]), 64'(8'hBB));
        check("t2_rx2",      64'(rx_q[rx_base + 2]), 64'(8'hAA));
        check("t2_dones",    64'(done_cnt[2] - done_base[2]), 64'(1));
        check("t2_mode",     64'(mode_log[$]), 64'(2'b11));
        check("t2_mode_held", 64'(mode_bad - mb_base), 64'(0));

        // All four requesting after reset: rotation 0,1,2,3,0.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req_len = 16'h1111; req_mode = '0;
        snap();
        req = 4'b1111;
        n = 0;
        while (grant_log.size() - g_base < 5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t3_five_grants_seen", 64'(grant_log.size() - g_base >= 5), 64'(1));
        req = '0;
        repeat (60) @(negedge clk);
        for (int k = 0; k < 5; k++)
            check($sformatf("t3_grant%0d", k), 64'(grant_log[g_base + k]), 64'(rr_exp[k]));
        check("t3_grant_total", 64'(grant_log.size() - g_base), 64'(5));
        check("t3_dones_r0", 64'(done_cnt[0] - done_base[0]), 64'(2));
        check("t3_dones_r3", 64'(done_cnt[3] - done_base[3]), 64'(1));

        // len=0 behaves as one byte.
        txbuf[3][0] = 8'h42; req_len[15:12] = 4'd0;
        snap();
        @(negedge clk); req[3] = 1'b1;
        wait_done(3, 100, "t4a");
        check("t4a_acks",  64'(ack_cnt[3] - ack_base[3]), 64'(1));
        check("t4a_rx_n",  64'(rx_q.size() - rx_base), 64'(1));
        check("t4a_rx0",   64'(rx_q[rx_base]), 64'(8'hDB));
        check("t4a_dones", 64'(done_cnt[3] - done_base[3]), 64'(1));

        // Maximum burst: 15 bytes.
        for (int k = 0; k < 16; k++) txbuf[0][k] = 8'(k);
        req_len[3:0] = 4'd15;
        snap();
        @(negedge clk); req[0] = 1'b1;
        wait_done(0, 600, "t4b");
        check("t4b_acks",    64'(ack_cnt[0] - ack_base[0]), 64'(15));
        check("t4b_rx_n",    64'(rx_q.size() - rx_base), 64'(15));
        check("t4b_rx_first", 64'(rx_q[rx_base]), 64'(8'h99));
        check("t4b_rx_last", 64'(rx_q[rx_base + 14]), 64'(8'h97));
        check("t4b_dones",   64'(done_cnt[0] - done_base[0]), 64'(1));

        // Reset while byte 2 of 3 is running.
        txbuf[1][0] = 8'h01; txbuf[1][1] = 8'h02; txbuf[1][2] = 8'h03;
        req_len[7:4] = 4'd3; req_mode[3:2] = 2'b01;
        snap();
        @(negedge clk); req[1] = 1'b1;
        n = 0;
        while (!((ack_cnt[1] - ack_base[1]) == 2 && eng_en) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_byte2_running", 64'((ack_cnt[1] - ack_base[1]) == 2 && eng_en), 64'(1));
        rst = 1'b1; req[1] = 1'b0;
        @(negedge clk);
        check("t5_outs_zero", 64'(outs), 64'(0));
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_no_done", 64'(done_cnt[1] - done_base[1]), 64'(0));

        txbuf[0][0] = 8'h5A; req_len[3:0] = 4'd1; req_mode[1:0] = 2'b00;
        snap();
        @(negedge clk); req[0] = 1'b1;
        wait_done(0, 100, "t5b");
        check("t5b_rx0",   64'(rx_q[rx_base]), 64'(8'hC3));
        check("t5b_dones", 64'(done_cnt[0] - done_base[0]), 64'(1));
        check("t5b_grant", 64'(grant_log[$]), 64'(0));

        check("we_en_never_both", 64'(both_cnt), 64'(0));
        check("no_req_err", 64'(err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3]), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Controller that shares one base SPI byte engine among NREQ requesters and runs multi-byte bursts on each requester's behalf.
- Arbitrates requesters round-robin, applies the winner's CPOL/CPHA, and sequences the engine's en/we/oe controls byte by byte.
- Returns each received byte to the owner and signals the end of every burst.
- Sits between the CPU-side peripheral logic and the SPI engine. The top level maps eng_wdata/eng_rdata onto the engine's bidirectional data bus.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LENW, 4, width of each burst-length field.
- TIMEOUT, 1024, per-byte watchdog limit in clk cycles (only used with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NREQ  level request per requester; held until its req_done
- req_len  in  NREQ*LENW  bytes per burst for each requester; 0 is treated as 1
- req_mode  in  NREQ*2  per-requester {cpol,cpha}
- tx_data  in  NREQ*8  current tx byte for each requester
- grant  out  NREQ  one-hot owner of the engine
- tx_ack  out  NREQ  one-cycle pulse when the owner's tx byte has been consumed
- rx_valid  out  1  one-cycle pulse when rx_data is valid for the granted requester
- rx_data  out  8  received byte
- req_done  out  NREQ  one-cycle pulse at burst end
- req_err  out  NREQ  one-cycle pulse on burst abort (optional feature only)
- eng_en, eng_we, eng_oe  out  1 each  engine controls
- eng_cpol, eng_cpha  out  1 each  engine mode
- eng_wdata  out  8  byte to the engine
- eng_rdata  in  8  byte from the engine
- eng_busy, eng_done  in  1 each  engine status

Behaviour:
- Reset: every output is 0, state is IDLE, and the round-robin pointer is 0.
- Arbitration: round-robin starting at the index after the last granted requester.
  - grant changes only in ARB.
  - Burst length and mode are latched in ARB.
  - eng_cpol/eng_cpha are registered and held for the whole burst.
- States:
  - IDLE: if any req is set, go to ARB.
  - ARB: choose the winner, set grant, load the byte counter (len-1), go to LOAD.
  - LOAD: eng_we=1, eng_wdata = winner's tx_data; one cycle; pulse tx_ack[winner]; go to RUN.
  - RUN: eng_en=1; on eng_done=1, go to DRAIN.
  - DRAIN: eng_en = eng_busy (combinational) so the engine returns to idle and stays there; when eng_busy=0, go to CAPT.
  - CAPT: eng_oe=1, register eng_rdata at the end of the cycle, pulse rx_valid next cycle.
    - If the counter is 0: go to FIN.
    - Otherwise: decrement the counter, go to LOAD.
  - FIN: pulse req_done[winner], clear grant, advance the pointer, go to IDLE.
- Latency: ARB is one cycle after req.
  - Each byte costs LOAD + engine time + DRAIN + CAPT.
  - One idle cycle separates bursts.
- eng_we and eng_en are never asserted in the same cycle. eng_oe is asserted only in CAPT.
- The engine deasserts ss between bytes; this is accepted behaviour.
- req dropping mid-burst is ignored: the burst completes.
- A requester re-asserting req immediately after its own req_done loses to any other pending requester.
- The byte counter is LENW bits; len=2^LENW-1 is the maximum burst length.
- rst mid-burst: return to IDLE with all outputs 0 on the next edge. The engine is reset by the same rst.

Optional Feature:
- SPI_ARB_TIMEOUT_EN: adds a cycle counter cleared in LOAD and incremented in RUN and DRAIN.
  - On reaching TIMEOUT: drive eng_en=0, pulse req_err[winner] instead of req_done, then go to FIN without rx_valid. The pointer still advances.
- Without the macro: no counter exists, req_err is tied to 0, and RUN waits indefinitely.

Test Plan:
- Single requester 1, len=1, mode=00, tx=0xA5, engine echoes 0x3C → one tx_ack[1], rx_valid with rx_data=0x3C, req_done[1]; eng_cpol=0, eng_cpha=0.
- Requester 2, len=3, mode=11, tx bytes 0x11/0x22/0x33 → three tx_ack pulses, three rx_valid pulses in order, one req_done[2]; eng_cpol=1 and eng_cpha=1 held throughout.
- req=4'b1111 held continuously → grants in order 0,1,2,3,0; no requester is granted twice before the others.
- len=0 → exactly one byte is transferred; len=15 → fifteen bytes, then req_done.
- rst asserted during RUN of byte 2 of 3 → all outputs are 0 the next cycle, no req_done; a subsequent request from requester 0 is served normally.
- With SPI_ARB_TIMEOUT_EN, TIMEOUT=16, eng_done stuck at 0 → req_err pulses 16 cycles after LOAD; eng_en drops; the next requester is granted.
